// File: rtl/bec_la_bridge.sv
// bec_la_bridge: logic-analyzer command bridge that loads BEC operands/key, sequences the core and reads results back.
module bec_la_bridge #(
  parameter int FIELD_W = 163,
  parameter int NUM_OPS = 6,
  parameter int CHUNK_W = 82,
  parameter int NUM_RES = 2,
  parameter int TIMEOUT = 2000
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic [127:0]       la_data_in,
  output logic [127:0]       la_data_out,
  input  logic [3:0]         becStatus,
  input  logic               load_data,
  input  logic               next_key,
  input  logic [NUM_RES-1:0] res_bit,
  output logic [NUM_OPS-1:0] op_bit,
  output logic               ki,
  output logic               master_ena_proc
);
  localparam int NCH = (FIELD_W + CHUNK_W - 1) / CHUNK_W;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [7:0] MAX_SLOT = 8'(NUM_OPS);
  localparam logic [7:0] RES_SLOTS = 8'(NUM_RES);
  localparam logic [5:0] NCH_V = 6'(NCH);
  localparam logic [5:0] LAST_C = 6'(NCH - 1);
  localparam logic [WW-1:0] WD_END = WW'(TIMEOUT - 1);
  localparam logic [2:0] IDLE = 3'd0, WRITE = 3'd1, UPLOAD = 3'd2, PROC = 3'd3, DOWNLOAD = 3'd4, READ = 3'd5;
  logic [2:0] state_q, state_d;
  logic stb_q, err_q, err_d, to_q, to_d, ena_q;
  logic [NUM_OPS:0] mask_q, mask_d;
  logic [FIELD_W-1:0] ops_q [NUM_OPS+1];
  logic [FIELD_W-1:0] ops_d [NUM_OPS+1];
  logic [FIELD_W-1:0] res_q [NUM_RES];
  logic [FIELD_W-1:0] res_d [NUM_RES];
  logic [FIELD_W-1:0] rsel;
  logic [CHUNK_W-1:0] rd_q, rd_d;
  logic [WW-1:0] wd_q, wd_d;
  logic xfer, w_ok, r_ok, unused_ok;
  logic [15:0] cmd;
  logic [7:0] slot;
  logic [5:0] chunk;
  logic [CHUNK_W-1:0] pay;
  assign xfer = la_data_in[96] ^ stb_q;
  assign cmd = la_data_in[31:16];
  assign slot = la_data_in[95:88];
  assign chunk = la_data_in[87:82];
  assign pay = la_data_in[CHUNK_W-1:0];
  assign w_ok = slot <= MAX_SLOT && chunk < NCH_V;
  assign r_ok = slot < RES_SLOTS && chunk < NCH_V;
  assign unused_ok = ^{la_data_in[127:97], becStatus[1]};
  always_comb begin
    state_d = state_q;
    err_d = err_q;
    to_d = to_q;
    mask_d = mask_q;
    ops_d = ops_q;
    res_d = res_q;
    rd_d = rd_q;
    rsel = '0;
    if (xfer && cmd == 16'hABFF) begin
      state_d = IDLE;
      mask_d = '0;
      err_d = 1'b0;
      to_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (xfer && cmd == 16'hAB30) begin
          state_d = WRITE;
          err_d = 1'b0;
          to_d = 1'b0;
        end
        WRITE: if (xfer && cmd == 16'hAB31) begin
          if (w_ok) begin
            for (int i = 0; i <= NUM_OPS; i++)
              if (slot == 8'(i)) begin
                for (int k = 0; k < NCH; k++)
                  if (chunk == 6'(k))
                    for (int b = 0; b < CHUNK_W; b++)
                      if (k * CHUNK_W + b < FIELD_W) ops_d[i][k*CHUNK_W+b] = pay[b];
                if (chunk == LAST_C) mask_d[i] = 1'b1;
              end
          end else err_d = 1'b1;
        end else if (xfer && cmd == 16'hAB41) begin
          if (&mask_q) state_d = UPLOAD;
          else err_d = 1'b1;
        end
        UPLOAD: begin
          if (load_data) for (int i = 0; i < NUM_OPS; i++) ops_d[i] = ops_q[i] << 1;
          if (becStatus[2]) state_d = PROC;
          else if (wd_q == WD_END) begin
            state_d = IDLE;
            to_d = 1'b1;
          end
        end
        PROC: begin
          if (next_key) ops_d[NUM_OPS] = ops_q[NUM_OPS] >> 1;
          if (becStatus[3]) state_d = DOWNLOAD;
          else if (wd_q == WD_END) begin
            state_d = IDLE;
            to_d = 1'b1;
          end
        end
        DOWNLOAD: begin
          for (int j = 0; j < NUM_RES; j++) res_d[j] = {res_q[j][FIELD_W-2:0], res_bit[j]};
          if (becStatus[0]) state_d = READ;
          else if (wd_q == WD_END) begin
            state_d = IDLE;
            to_d = 1'b1;
          end
        end
        READ: if (xfer && cmd == 16'hAB60) begin
          rd_d = '0;
          if (r_ok) begin
            for (int j = 0; j < NUM_RES; j++) if (slot == 8'(j)) rsel = res_q[j];
            for (int k = 0; k < NCH; k++)
              if (chunk == 6'(k))
                for (int b = 0; b < CHUNK_W; b++)
                  if (k * CHUNK_W + b < FIELD_W) rd_d[b] = rsel[k*CHUNK_W+b];
          end else err_d = 1'b1;
        end else if (xfer && cmd == 16'hAB50) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    // the watchdog restarts on every state entry and idles outside the core-driven states
    wd_d = (state_d == state_q && (state_q == UPLOAD || state_q == PROC || state_q == DOWNLOAD)) ? wd_q + 1'b1 : '0;
  end
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      stb_q <= 1'b0;
      err_q <= 1'b0;
      to_q <= 1'b0;
      ena_q <= 1'b0;
      mask_q <= '0;
      ops_q <= '{default: '0};
      res_q <= '{default: '0};
      rd_q <= '0;
      wd_q <= '0;
    end else begin
      state_q <= state_d;
      stb_q <= la_data_in[96];
      err_q <= err_d;
      to_q <= to_d;
      ena_q <= state_d == PROC;
      mask_q <= mask_d;
      ops_q <= ops_d;
      res_q <= res_d;
      rd_q <= rd_d;
      wd_q <= wd_d;
    end
  end
  always_comb begin
    op_bit = '0;
    for (int i = 0; i < NUM_OPS; i++) op_bit[i] = ops_q[i][FIELD_W-1];
  end
  assign ki = ops_q[NUM_OPS][0];
  assign master_ena_proc = ena_q;
  assign la_data_out = {1'b0, state_q, err_q, to_q, 8'(mask_q), 17'b0, stb_q, 14'b0, 82'(rd_q)};
endmodule

// File: tb/tb_bec_la_bridge.sv
// tb_bec_la_bridge: directed checks of load, sequencing, readback, watchdog and reset of bec_la_bridge.
module tb_bec_la_bridge;
  logic wb_clk_i = 1'b0;
  logic wb_rst_i = 1'b1;
  logic [127:0] la_data_in = '0;
  logic [127:0] la_data_out;
  logic [3:0] becStatus = '0;
  logic load_data = 1'b0;
  logic next_key = 1'b0;
  logic [1:0] res_bit = '0;
  logic [5:0] op_bit;
  logic ki, master_ena_proc;
  logic tog = 1'b0;
  logic [3:0] pat = 4'b1011;
  int total = 0;
  int bad = 0;
  bec_la_bridge dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .la_data_in(la_data_in), .la_data_out(la_data_out),
    .becStatus(becStatus), .load_data(load_data), .next_key(next_key), .res_bit(res_bit),
    .op_bit(op_bit), .ki(ki), .master_ena_proc(master_ena_proc)
  );
  always #5 wb_clk_i = ~wb_clk_i;
  task step(input int n);
    repeat (n) @(posedge wb_clk_i);
    #1;
  endtask
  task chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task send(input logic [15:0] cmd, input logic [7:0] s, input logic [5:0] c, input logic [81:0] p);
    logic [127:0] v;
    v = 128'(p);
    v[31:16] = cmd;
    tog = ~tog;
    v[96] = tog;
    v[95:88] = s;
    v[87:82] = c;
    la_data_in = v;
    step(1);
  endtask
  function automatic logic [81:0] pay(input int i, input int c);
    logic [81:0] p;
    p = 82'((i << 4) | c);
    if (i == 0 && c == 1) p = 82'(1) << 80;
    if (i == 5 && c == 1) p = 82'(3) << 79;
    if (i == 6) p = (c == 0) ? 82'(5) : '0;
    return p;
  endfunction
  task load_all(input int skip);
    for (int i = 0; i < 7; i++)
      if (i != skip)
        for (int c = 0; c < 2; c++) send(16'hAB31, 8'(i), 6'(c), pay(i, c));
  endtask
  initial begin
    step(2);
    chk("rst_out", la_data_out, '0);
    chk("rst_io", {master_ena_proc, ki, op_bit}, '0);
    wb_rst_i = 1'b0;
    step(1);
    send(16'hAB41, 0, 0, '0);
    chk("idle_ignore", la_data_out[127:122], '0);
    chk("ack", la_data_out[96], 1'b1);
    send(16'hAB30, 0, 0, '0);
    chk("to_write", la_data_out[127:124], 4'd1);
    send(16'hAB31, 9, 0, '0);
    chk("bad_slot", {la_data_out[123], la_data_out[121:114]}, 9'h100);
    send(16'hABFF, 0, 0, '0);
    chk("abort", la_data_out[127:114], '0);
    send(16'hAB30, 0, 0, '0);
    send(16'hAB31, 0, 2, '0);
    chk("bad_chunk", {la_data_out[123], la_data_out[121:114]}, 9'h100);
    send(16'hABFF, 0, 0, '0);
    send(16'hAB30, 0, 0, '0);
    load_all(3);
    send(16'hAB41, 0, 0, '0);
    chk("miss_slot3", la_data_out[127:114], {4'd1, 1'b1, 1'b0, 8'h77});
    send(16'hABFF, 0, 0, '0);
    send(16'hAB30, 0, 0, '0);
    send(16'hAB31, 0, 0, pay(0, 0));
    chk("mask_c0", la_data_out[121:114], 8'h00);
    send(16'hAB31, 0, 1, pay(0, 1));
    chk("mask_c1", la_data_out[121:114], 8'h01);
    for (int i = 1; i < 7; i++)
      for (int c = 0; c < 2; c++) send(16'hAB31, 8'(i), 6'(c), pay(i, c));
    send(16'hAB60, 0, 0, '0);
    chk("full_load", la_data_out[127:114], {4'd1, 1'b0, 1'b0, 8'h7F});
    send(16'hAB41, 0, 0, '0);
    chk("upload", la_data_out[127:114], {4'd2, 1'b0, 1'b0, 8'h7F});
    chk("ops_pre", {ki, op_bit}, {1'b1, 6'b100001});
    load_data = 1'b1;
    step(1);
    load_data = 1'b0;
    chk("ops_shift", {ki, op_bit}, {1'b1, 6'b100000});
    becStatus = 4'h4;
    step(1);
    becStatus = 4'h0;
    chk("proc", {la_data_out[127:124], master_ena_proc}, {4'd3, 1'b1});
    load_data = 1'b1;
    step(1);
    load_data = 1'b0;
    chk("proc_noload", op_bit, 6'b100000);
    next_key = 1'b1;
    step(1);
    chk("ki_1", ki, 1'b0);
    step(1);
    next_key = 1'b0;
    chk("ki_2", ki, 1'b1);
    becStatus = 4'h8;
    step(1);
    becStatus = 4'h0;
    chk("download", {la_data_out[127:124], master_ena_proc}, {4'd4, 1'b0});
    for (int k = 0; k < 163; k++) begin
      res_bit = {(k >= 159) ? pat[162-k] : 1'b0, 1'b1};
      becStatus = (k == 162) ? 4'h1 : 4'h0;
      step(1);
    end
    becStatus = 4'h0;
    res_bit = '0;
    chk("read_state", la_data_out[127:124], 4'd5);
    send(16'hAB30, 0, 0, '0);
    chk("read_ignore", la_data_out[127:122], {4'd5, 2'b00});
    send(16'hAB60, 0, 1, '0);
    chk("rd_s0c1", la_data_out[81:0], {1'b0, {81{1'b1}}});
    send(16'hAB60, 0, 0, '0);
    chk("rd_s0c0", la_data_out[81:0], {82{1'b1}});
    send(16'hAB60, 2, 0, '0);
    chk("rd_badslot", {la_data_out[123], la_data_out[81:0]}, {1'b1, 82'd0});
    send(16'hAB60, 1, 0, '0);
    chk("rd_s1c0", la_data_out[81:0], 82'hB);
    send(16'hAB60, 0, 0, '0);
    send(16'hAB60, 0, 2, '0);
    chk("rd_badchunk", la_data_out[81:0], 82'd0);
    send(16'hAB50, 0, 0, '0);
    chk("to_idle", la_data_out[127:124], 4'd0);
    send(16'hAB30, 0, 0, '0);
    chk("err_clear", la_data_out[127:122], {4'd1, 2'b00});
    send(16'hAB41, 0, 0, '0);
    step(1999);
    chk("wd_hold", la_data_out[127:124], 4'd2);
    step(1);
    chk("wd_fire", {la_data_out[127:124], la_data_out[122]}, {4'd0, 1'b1});
    send(16'hAB30, 0, 0, '0);
    chk("to_clear", {la_data_out[127:124], la_data_out[122]}, {4'd1, 1'b0});
    send(16'hAB41, 0, 0, '0);
    step(1999);
    becStatus = 4'h4;
    step(1);
    becStatus = 4'h0;
    chk("status_wins", {la_data_out[127:124], la_data_out[122]}, {4'd3, 1'b0});
    chk("pre_rst", {master_ena_proc, ki, op_bit}, {1'b1, 1'b1, 6'b100000});
    #2;
    wb_rst_i = 1'b1;
    #1;
    chk("rst_mid_out", la_data_out, '0);
    chk("rst_mid_io", {master_ena_proc, ki, op_bit}, '0);
    step(2);
    wb_rst_i = 1'b0;
    step(1);
    chk("post_rst", la_data_out[127:114], '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bec_la_bridge.md
BEC_LA_BRIDGE -- requirements
Module: bec_la_bridge

Interface
REQ-001 SHALL provide parameter FIELD_W, default 163: operand and result field width in bits.
REQ-002 SHALL provide parameter NUM_OPS, default 6, legal range 1..7: serial operand channels; slot NUM_OPS is the key.
REQ-003 SHALL provide parameter CHUNK_W, default 82, legal range 1..82: payload bits per LA transfer; NCH = ceil(FIELD_W/CHUNK_W), NCH ≤ 64.
REQ-004 SHALL provide parameter NUM_RES, default 2: serial result channels.
REQ-005 SHALL provide parameter TIMEOUT, default 2000: watchdog limit in cycles.
REQ-006 SHALL use one clock; reset is asynchronous and active-high. Ports are named wb_clk_i and wb_rst_i.
REQ-007 Port wb_clk_i, input, 1 bit: sole clock.
REQ-008 Port wb_rst_i, input, 1 bit: asynchronous active-high reset.
REQ-009 Port la_data_in, input, 128 bits: command bus; [31:16] cmd, [96] strobe toggle, [95:88] slot, [87:82] chunk, [81:0] payload.
REQ-010 Port la_data_out, output, 128 bits, registered: [127:124] state code, [123] err, [122] timeout, [121:114] loaded mask (zero-extended), [96] ack toggle, [81:0] read data.
REQ-011 Port becStatus, input, 4 bits: [2] upload complete, [3] processing done, [0] download complete.
REQ-012 Port load_data, input, 1 bit: operand shift strobe.
REQ-013 Port next_key, input, 1 bit: key shift strobe.
REQ-014 Port res_bit, input, NUM_RES bits: serial result inputs.
REQ-015 Port op_bit, output, NUM_OPS bits: op_bit[i] = operand i bit [FIELD_W-1].
REQ-016 Port ki, output, 1 bit: key bit [0].
REQ-017 Port master_ena_proc, output, 1 bit, registered: high only in PROC.

Function
REQ-018 States and codes: IDLE=0, WRITE=1, UPLOAD=2, PROC=3, DOWNLOAD=4, READ=5; la_data_out[127:124] SHALL show the current state code.
REQ-019 A transfer SHALL occur only in a cycle where la_data_in[96] differs from its registered previous value; ack [96] SHALL copy that strobe value 1 cycle later.
REQ-020 Transitions: IDLE->WRITE on cmd 0xAB30; WRITE->UPLOAD on cmd 0xAB41 only if the loaded mask is all-ones, else err=1 and remain in WRITE; UPLOAD->PROC on becStatus[2]; PROC->DOWNLOAD on becStatus[3]; DOWNLOAD->READ on becStatus[0]; READ->IDLE on cmd 0xAB50.
REQ-021 Cmd 0xABFF with a strobe SHALL force IDLE from any state, clear the mask and clear err.
REQ-022 WRITE, cmd 0xAB31 with strobe: bits [c*CHUNK_W +: CHUNK_W] of the slot register SHALL load from payload; bits at or above FIELD_W SHALL be discarded.
REQ-023 Writing the last chunk of slot s (c = NCH-1) SHALL set mask[s].
REQ-024 Slot > NUM_OPS or chunk ≥ NCH SHALL set err=1 and write nothing.
REQ-025 UPLOAD: each load_data cycle SHALL shift all operand registers left by 1, shifting in 0.
REQ-026 PROC: each next_key cycle SHALL shift the key register right by 1; load_data in PROC SHALL be ignored.
REQ-027 DOWNLOAD: each cycle SHALL shift result j as (res<<1) | res_bit[j].
REQ-028 READ, cmd 0xAB60 with strobe: la_data_out[81:0] SHALL present the result slot/chunk, zero-extended, 1 cycle later; slot ≥ NUM_RES or chunk ≥ NCH SHALL return 0 and set err.
REQ-029 Watchdog: in UPLOAD, PROC or DOWNLOAD, a counter SHALL reset on state entry; reaching TIMEOUT cycles SHALL set timeout=1 and go to IDLE.
REQ-030 Commands not legal in the current state SHALL be ignored, with no err.
REQ-031 When a status bit and a timeout occur in the same cycle, the status-driven transition SHALL win.

Reset
REQ-032 Asserting wb_rst_i at any time, including mid-UPLOAD, SHALL immediately force IDLE.
REQ-033 Reset SHALL clear every register: la_data_out=0, master_ena_proc=0, op_bit=0, ki=0, mask=0, err=0, timeout=0, watchdog=0.
REQ-034 err and timeout SHALL otherwise clear only on 0xAB30 accepted in IDLE or on 0xABFF.

Verification
REQ-035 Full load with defaults (7 slots × 2 chunks, strobe toggled each write) -> mask=0x7F; then 0xAB41 -> state 2, err=0.
REQ-036 0xAB41 with slot 3 missing -> state stays 1, err=1, mask=0x77.
REQ-037 Slot 0 = 1 followed by zeros in the top chunk, then load_data pulsed 1 cycle -> op_bit[0]=1 before the pulse and 0 after it; key=0x5 with next_key ×2 -> ki sequence 1,0,1.
REQ-038 DOWNLOAD res_bit[0]=1 for 163 cycles, then becStatus[0] -> READ; 0xAB60 slot 0 chunk 1 -> la_data_out[80:0]=all ones (81 bits).
REQ-039 UPLOAD held with no becStatus for 2000 cycles -> IDLE, timeout=1; reset asserted mid-PROC -> all outputs 0 in the same cycle.
